tl_cntr_w_left: RTL and testbench
=================================

Name: tl_cntr_w_left

Overview:
- Moore-type traffic-light controller for a two-street intersection (street A and street B), each with a dedicated left-turn phase.
- Sequencing per cycle: A green, A yellow, A left, A yellow, B green, B yellow, B left, B yellow, then back to A green.
- Per-direction traffic sensors hold a green or left phase for as long as that direction reports traffic.
- Sits at top level of the intersection design; outputs drive the lamp decoders directly.

Parameters:
- none (fixed 8-state controller; encodings are constants in the shared package)

Ports:
- clk      input  1  system clock; all state changes on rising edge
- reset_n  input  1  one clock; reset is synchronous and active-high (asserted = 1 despite the _n suffix, sampled only on rising clk)
- Ta       input  1  traffic present on street A straight
- Tal      input  1  traffic present in street A left-turn lane
- Tb       input  1  traffic present on street B straight
- Tbl      input  1  traffic present in street B left-turn lane
- La       output 2  street A light code
- Lb       output 2  street B light code

Behaviour:
- Light codes: GREEN=2'b00, YELLOW=2'b01, LEFT=2'b10, RED=2'b11.
- State register: 3 bits, states S0..S7 encoded 3'd0..3'd7.
- Reset:
  - reset_n=1 at a rising edge forces S0 regardless of sensor inputs.
  - Reset has priority over all transitions.
  - Outputs after reset: La=GREEN(00), Lb=RED(11).
- Transitions, evaluated each rising edge with reset_n=0:
  - S0 (A green): Ta=1 -> S0; Ta=0 -> S1
  - S1 (A yellow): -> S2 unconditionally
  - S2 (A left): Tal=1 -> S2; Tal=0 -> S3
  - S3 (A yellow): -> S4 unconditionally
  - S4 (B green): Tb=1 -> S4; Tb=0 -> S5
  - S5 (B yellow): -> S6 unconditionally
  - S6 (B left): Tbl=1 -> S6; Tbl=0 -> S7
  - S7 (B yellow): -> S0 unconditionally
- Sensor sensitivity: only the sensor belonging to the current hold state matters; all others are ignored.
- Outputs are pure functions of state (Moore, no input-to-output path); they change only after a clock edge:
  - La: S0=GREEN, S1=YELLOW, S2=LEFT, S3=YELLOW, S4..S7=RED
  - Lb: S0..S3=RED, S4=GREEN, S5=YELLOW, S6=LEFT, S7=YELLOW
- Safety invariant: La and Lb are never both non-RED in any state.
- Latency:
  - Sensor drop is seen at the next edge; lights change 1 cycle after the sensor falls.
  - Each yellow lasts exactly 1 cycle.
  - Minimum full cycle with all sensors low is 8 clocks.
- Mid-operation reset from any state returns to S0 on that edge.
- Any illegal state value (unreachable with a 3-bit full encoding) must go to S0.

Decomposition:
- Package tl_pkg holds:
  - light-code localparams GREEN/YELLOW/LEFT/RED
  - state localparams S0..S7
- Natural sub-modules: tl_ns_lgc (combinational next-state logic) and tl_o_lgc (state -> La/Lb decode).
- Top module holds the state flip-flops with synchronous reset.

Test Plan:
- Reset: reset_n=1 for 2 edges with all sensors 1 -> state S0, La=00, Lb=11; release, Ta=1 held 3 cycles -> La stays 00.
- A cycle: after reset, Ta=0 -> successive edges give La=01, then 10 (Tal=0) -> 01 -> 11 with Lb=00.
- Left hold: in S2 with Tal=1 for 4 edges -> La=10, Lb=11 throughout; Tal=0 -> next edge La=01.
- B side: in S4 hold Tb=1 -> Lb=00; Tb=0 -> Lb=01, 10; Tbl=1 holds 10; Tbl=0 -> 01 -> S0 (La=00, Lb=11).
- Free run: all sensors 0 -> period of exactly 8 clocks, La/Lb sequence matches table; assert never both != 11.
- Reset mid-phase: reset_n=1 while in S6 -> next edge La=00, Lb=11; irrelevant sensors toggling (e.g. Tb in S0) cause no change.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared constants for the two-street traffic-light controller with left-turn phases.
package tl_pkg;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] LEFT   = 2'b10;
  localparam logic [1:0] RED    = 2'b11;

  // S0..S3 serve street A (green, yellow, left, yellow); S4..S7 mirror them for street B.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } state_t;

endpackage

// File: rtl/tl_ns_lgc.sv
// Next-state logic: each hold state watches only its own sensor; yellows always advance.
module tl_ns_lgc
  import tl_pkg::*;
(
  input  state_t state,
  input  logic   Ta,
  input  logic   Tal,
  input  logic   Tb,
  input  logic   Tbl,
  output state_t next_state
);

  always_comb begin
    next_state = S0;
    case (state)
      S0:      next_state = Ta  ? S0 : S1;
      S1:      next_state = S2;
      S2:      next_state = Tal ? S2 : S3;
      S3:      next_state = S4;
      S4:      next_state = Tb  ? S4 : S5;
      S5:      next_state = S6;
      S6:      next_state = Tbl ? S6 : S7;
      S7:      next_state = S0;
      default: next_state = S0;
    endcase
  end

endmodule

// File: rtl/tl_o_lgc.sv
// Lamp decode: light codes as a pure function of state; one street is always RED.
module tl_o_lgc
  import tl_pkg::*;
(
  input  state_t     state,
  output logic [1:0] La,
  output logic [1:0] Lb
);

  always_comb begin
    La = RED;
    Lb = RED;
    case (state)
      S0:      La = GREEN;
      S1:      La = YELLOW;
      S2:      La = LEFT;
      S3:      La = YELLOW;
      S4:      Lb = GREEN;
      S5:      Lb = YELLOW;
      S6:      Lb = LEFT;
      S7:      Lb = YELLOW;
      default: begin
        La = RED;
        Lb = RED;
      end
    endcase
  end

endmodule

// File: rtl/tl_cntr_w_left.sv
// Top of the traffic-light controller: state register with synchronous active-high reset.
module tl_cntr_w_left
  import tl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tal,
  input  logic       Tb,
  input  logic       Tbl,
  output logic [1:0] La,
  output logic [1:0] Lb
);

  state_t     state;
  state_t     next_state;
  logic [1:0] la_next;
  logic [1:0] lb_next;

  tl_ns_lgc u_ns_lgc (
    .state      (state),
    .Ta         (Ta),
    .Tal        (Tal),
    .Tb         (Tb),
    .Tbl        (Tbl),
    .next_state (next_state)
  );

  // Decoding the next state lets the lamp outputs be registered alongside the
  // state while still tracking the current state exactly (no input-to-output path).
  tl_o_lgc u_o_lgc (
    .state (next_state),
    .La    (la_next),
    .Lb    (lb_next)
  );

  // reset_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state <= S0;
      La    <= GREEN;
      Lb    <= RED;
    end else begin
      state <= next_state;
      La    <= la_next;
      Lb    <= lb_next;
    end
  end

endmodule

// File: tb/tb_tl_cntr_w_left.sv
// Directed bench for tl_cntr_w_left: walks every phase, holds, reset cases and free run.
module tb_tl_cntr_w_left;

  logic       clk;
  logic       reset_n;
  logic       Ta, Tal, Tb, Tbl;
  logic [1:0] La, Lb;

  int checks;
  int errors;
  bit started;

  logic [1:0] exp_la [8];
  logic [1:0] exp_lb [8];

  tl_cntr_w_left dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Ta      (Ta),
    .Tal     (Tal),
    .Tb      (Tb),
    .Tbl     (Tbl),
    .La      (La),
    .Lb      (Lb)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // never both streets showing a non-RED lamp once the controller is initialised
  always @(negedge clk) begin
    if (started) begin
      assert (La == 2'b11 || Lb == 2'b11)
        else $error("safety violated La=%b Lb=%b", La, Lb);
    end
  end

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lights(input string tag, input logic [1:0] la, input logic [1:0] lb);
    check_val({tag, "_la"}, {6'd0, La}, {6'd0, la});
    check_val({tag, "_lb"}, {6'd0, Lb}, {6'd0, lb});
  endtask

  task automatic set_sensors(input logic a, input logic al, input logic b, input logic bl);
    Ta  = a;
    Tal = al;
    Tb  = b;
    Tbl = bl;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    started = 1'b0;
    exp_la = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
    exp_lb = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b01};

    // reset with every sensor asserted
    reset_n = 1'b1;
    set_sensors(1, 1, 1, 1);
    step();
    step();
    started = 1'b1;
    check_lights("reset", 2'b00, 2'b11);
    check_val("reset_state", {5'd0, dut.state}, 8'd0);

    // A green held by Ta; other sensors ignored
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_lights("a_hold", 2'b00, 2'b11);
    end

    // A yellow, then left turn held by Tal
    Ta = 1'b0;
    step();
    check_lights("a_yel1", 2'b01, 2'b11);
    for (int i = 0; i < 4; i++) begin
      step();
      check_lights("a_left", 2'b10, 2'b11);
    end
    Tal = 1'b0;
    step();
    check_lights("a_yel2", 2'b01, 2'b11);

    // B green held by Tb
    for (int i = 0; i < 3; i++) begin
      step();
      check_lights("b_green", 2'b11, 2'b00);
    end
    Tb = 1'b0;
    step();
    check_lights("b_yel1", 2'b11, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step();
      check_lights("b_left", 2'b11, 2'b10);
    end
    Tbl = 1'b0;
    step();
    check_lights("b_yel2", 2'b11, 2'b01);
    step();
    check_lights("wrap_s0", 2'b00, 2'b11);

    // free run, all sensors low: period of exactly 8 clocks
    set_sensors(0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      step();
      check_lights("free", exp_la[i % 8], exp_lb[i % 8]);
      check_val("free_state", {5'd0, dut.state}, 8'(i % 8));
    end

    // walk to S6 and reset there
    for (int i = 1; i <= 6; i++) step();
    check_lights("pre_mid_reset", 2'b11, 2'b10);
    Tbl = 1'b1;
    reset_n = 1'b1;
    step();
    check_lights("mid_reset", 2'b00, 2'b11);
    reset_n = 1'b0;

    // irrelevant sensors toggling while A green is held
    Ta = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Tb  = ~Tb;
      Tal = ~Tal;
      step();
      check_lights("ignore", 2'b00, 2'b11);
    end

    // sensor drop seen at the very next edge
    Ta = 1'b0;
    step();
    check_lights("drop", 2'b01, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
